i2c_ioexp_target: RTL and testbench
===================================

# i2c_ioexp_target

Synthesizable I2C target emulating a 16-bit PCA9555-style IO expander: the responder end of the bus that `i2c_ioexp` masters. It decodes START/STOP, its 7-bit address and the command byte. It serves eight byte registers: input, output, polarity inversion and configuration, each for ports 0 and 1. It drives an active-low interrupt on input change. It is used as a bench/loopback model and as an on-FPGA expander for boards without the physical part.

## Interface
- `ADDR`, 7'h20, 7-bit target address.
- `OUT_RESET`, 16'hFFFF, reset value of output registers.
- `CFG_RESET`, 16'hFFFF, reset value of config registers (1 = input).
- `clk` input 1, system clock; sclk period ≥ 16 `clk` periods.
- `reset` input 1, synchronous, active-high.
- `sclk` input 1, I2C clock from master (async).
- `sdata_in` input 1, I2C data line as seen on the bus (async).
- `sdata_oe_n` output 1, 0 = pull SDA low, 1 = release.
- `io_in` input 16, pin levels, [15:8] = port 1.
- `io_out` output 16, output register value.
- `io_dir` output 16, config register value (1 = input, pin not driven).
- `int_n` output 1, active-low interrupt.

## Operation
- `sclk` and `sdata_in` each pass through a 2-FF synchronizer, then a registered edge detector.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- START from any state, including repeated START, goes to ADDR with bit count 0. STOP from any state goes to IDLE and releases SDA.
- Bits are sampled on SCL rising edges, MSB first. SDA changes are driven only after SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- ADDR: after 8 bits, if [7:1]==`ADDR` go to ADDR_ACK and drive ACK; otherwise go to IGNORE (never drive) until START/STOP.
- ADDR_ACK: when R/W=0 go to CMD. When R/W=1 load the byte at the pointer and go to RD.
- CMD: the 8-bit byte is acked. Pointer = byte[2:0]; bits [7:3] are ignored. Then go to WR.
- WR: each byte is acked.
  - Command 0/1 (input) is read-only: the write is discarded but still acked.
  - Commands 2–7 update their register at the 8th rising edge.
  - The pointer then toggles within its pair (ptr ^ 1).
- RD: drive byte bits, MSB first. At RD_ACK sample the master bit.
  - ACK (0): pointer ^= 1, load next byte, stay in RD.
  - NACK: release SDA and go to IGNORE.
- Input register value = `io_in` ^ polarity, snapshotted into the shift register at load time.
- Register map: 0/1 input, 2/3 output, 4/5 polarity, 6/7 config; even = port 0 = bits [7:0].
- Interrupt:
  - `int_n` goes low when any `io_in` bit with `io_dir`=1 differs from the last snapshot taken for its port.
  - `int_n` returns high when that port's input register is loaded for a read, or when the pins revert to the snapshot.
  - Snapshots are initialized from `io_in` at reset.

## Timing
- Reset values: `sdata_oe_n`=1, `int_n`=1, `io_out`=`OUT_RESET`, `io_dir`=`CFG_RESET`, polarity=0, pointer=0, state IDLE.
- Reset mid-transaction releases SDA in the same cycle as reset is sampled.
- Latency from a pin edge to the detected event: 3 `clk` cycles (2 sync + 1 edge register).
- ACK/data drive: `sdata_oe_n` updates 1 cycle after the detected SCL falling edge ending the 8th bit or the previous bit.
- The drive is held until the next detected SCL falling edge, then released or the next bit is driven.
- Register writes are visible on `io_out`/`io_dir` 1 cycle after the detected 8th rising edge of the data byte.
- `int_n` assertion: 4 cycles after an `io_in` change (3 sync/edge + 1 compare register). `io_in` is synchronized separately.
- A START/STOP that coincides with an SCL edge event takes priority over bit processing.

## Structure
- Package `i2c_ioexp_pkg`:
  - state enum `i2c_tgt_state_t`
  - command constants `CMD_IN0`…`CMD_CFG1` (3'd0–3'd7)
- Sub-module `i2c_line_sync`: 2-FF synchronizer plus edge detector. Instantiated once per bus line; outputs level, rise and fall strobes.
- Register file and FSM live in the top module, 120–400 lines total.

## Test plan
- Write 0x40 (addr 0x20 W), cmd 0x02, 0xA5, 0x3C, STOP → all four bytes acked, `io_out`=16'h3CA5.
- `io_in`=16'hAA55, polarity write 0x04/0xFF: read cmd 0x00 with repeated START 0x41, ACK then NACK → bytes 0xAA, 0xAA.
- Address 0x42 → no ACK (`sdata_oe_n` stays 1 the entire transaction); a following 0x40 transaction is acked normally.
- Config 0x06=0x0F, toggle `io_in`[0] → `int_n` low at 4 cycles. Toggle `io_in`[4] (output pin) → no interrupt. Read cmd 0x00 → `int_n` high.
- Write cmd 0x00 with data 0x12 → acked, no register changes. STOP mid-byte → IDLE, SDA released.
- Assert `reset` while driving ACK → `sdata_oe_n`=1 next cycle, `io_out`=16'hFFFF, `io_dir`=16'hFFFF.

Source files
------------

// File: rtl/i2c_ioexp_pkg.sv
// ---------------------------------------------------------------------------
// i2c_ioexp_pkg
// Shared types and constants for the PCA9555-style I2C IO expander target.
//   i2c_tgt_state_t : bus-level protocol state of the target FSM
//   CMD_*           : command byte pointer values (register map index)
// ---------------------------------------------------------------------------
package i2c_ioexp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CMD,
        ST_CMD_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    // Even pointers address port 0 (bits [7:0]), odd pointers port 1 (bits [15:8]).
    localparam logic [2:0] CMD_IN0  = 3'd0;
    localparam logic [2:0] CMD_IN1  = 3'd1;
    localparam logic [2:0] CMD_OUT0 = 3'd2;
    localparam logic [2:0] CMD_OUT1 = 3'd3;
    localparam logic [2:0] CMD_POL0 = 3'd4;
    localparam logic [2:0] CMD_POL1 = 3'd5;
    localparam logic [2:0] CMD_CFG0 = 3'd6;
    localparam logic [2:0] CMD_CFG1 = 3'd7;

endpackage

// File: rtl/i2c_ioexp_target_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings one asynchronous I2C bus line into the clk domain and flags edges.
//   clk, reset : system clock, synchronous active-high reset
//   line_in    : raw bus line (async)
//   level      : synchronized level, aligned with the rise/fall strobes
//   rise, fall : one-cycle strobes, 3 clk cycles after the pin edge
// ---------------------------------------------------------------------------
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_q, level_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        level_d = sync2_q;
        rise_d  = sync2_q & ~level_q;
        fall_d  = ~sync2_q & level_q;
    end

    // Lines reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_ioexp_target.sv
// ---------------------------------------------------------------------------
// i2c_ioexp_target
// I2C target emulating a 16-bit PCA9555-style IO expander.
//   clk, reset  : system clock, synchronous active-high reset
//   sclk        : I2C clock from the master (async)
//   sdata_in    : I2C data line as seen on the bus (async)
//   sdata_oe_n  : 0 = pull SDA low, 1 = release
//   io_in       : pin levels, [15:8] = port 1
//   io_out      : output register value
//   io_dir      : configuration register value (1 = input)
//   int_n       : active-low interrupt on change of an input pin
// ---------------------------------------------------------------------------
module i2c_ioexp_target
    import i2c_ioexp_pkg::*;
#(
    parameter logic [6:0]  ADDR      = 7'h20,
    parameter logic [15:0] OUT_RESET = 16'hFFFF,
    parameter logic [15:0] CFG_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        sdata_in,
    output logic        sdata_oe_n,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic [15:0] io_dir,
    output logic        int_n
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (sclk),
        .level   (scl_level),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (sdata_in),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_tgt_state_t state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q,   shift_d;
    logic [2:0]  ptr_q,     ptr_d;
    logic        rw_q,      rw_d;
    logic        oe_n_q,    oe_n_d;
    logic [15:0] out_q,     out_d;
    logic [15:0] pol_q,     pol_d;
    logic [15:0] cfg_q,     cfg_d;
    logic [15:0] snap_q,    snap_d;
    logic        int_n_q,   int_n_d;

    // Three stages so the pin-to-compare delay matches the bus lines' sync + edge path.
    logic [15:0] io_s1_q, io_s2_q, io_s3_q;

    logic        start_det, stop_det;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;
    logic        load_en;
    logic [2:0]  load_ptr;

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign rx_byte   = {shift_q[6:0], sda_level};

    function automatic logic [7:0] read_reg(input logic [2:0] p);
        logic [15:0] in_val;
        in_val = io_s3_q ^ pol_q;
        case (p)
            CMD_IN0:  read_reg = in_val[7:0];
            CMD_IN1:  read_reg = in_val[15:8];
            CMD_OUT0: read_reg = out_q[7:0];
            CMD_OUT1: read_reg = out_q[15:8];
            CMD_POL0: read_reg = pol_q[7:0];
            CMD_POL1: read_reg = pol_q[15:8];
            CMD_CFG0: read_reg = cfg_q[7:0];
            default:  read_reg = cfg_q[15:8];
        endcase
    endfunction

    assign load_ptr = (state_q == ST_RD_ACK) ? (ptr_q ^ 3'd1) : ptr_q;
    assign rd_byte  = read_reg(load_ptr);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        oe_n_d    = oe_n_q;
        out_d     = out_q;
        pol_d     = pol_q;
        cfg_d     = cfg_q;
        load_en   = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            oe_n_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            oe_n_d    = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = sda_level;
                            state_d = (rx_byte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                    end
                end
                // ACK states: the first SCL fall starts driving the ACK, the
                // second (after the master clocked it) ends the ACK slot.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (oe_n_q) begin
                            oe_n_d = 1'b0;
                        end else begin
                            bit_cnt_d = 3'd0;
                            if (rw_q) begin
                                load_en = 1'b1;
                                oe_n_d  = rd_byte[7];
                                shift_d = {rd_byte[6:0], 1'b0};
                                state_d = ST_RD;
                            end else begin
                                oe_n_d  = 1'b1;
                                state_d = ST_CMD;
                            end
                        end
                    end
                end
                ST_CMD: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d   = rx_byte[2:0];
                            state_d = ST_CMD_ACK;
                        end
                    end
                end
                ST_CMD_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (oe_n_q) begin
                            oe_n_d = 1'b0;
                        end else begin
                            oe_n_d    = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Input registers are read-only: the byte is acked but dropped.
                            case (ptr_q)
                                CMD_OUT0: out_d[7:0]  = rx_byte;
                                CMD_OUT1: out_d[15:8] = rx_byte;
                                CMD_POL0: pol_d[7:0]  = rx_byte;
                                CMD_POL1: pol_d[15:8] = rx_byte;
                                CMD_CFG0: cfg_d[7:0]  = rx_byte;
                                CMD_CFG1: cfg_d[15:8] = rx_byte;
                                default:  ;
                            endcase
                            ptr_d   = ptr_q ^ 3'd1;
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_RD: begin
                    if (scl_fall) begin
                        oe_n_d  = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RD_ACK;
                        end
                    end
                end
                // The next byte is loaded at the master's ACK; its MSB goes
                // out on the following SCL fall from ST_RD.
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        oe_n_d = 1'b1;
                    end else if (scl_rise) begin
                        if (!sda_level) begin
                            load_en   = 1'b1;
                            ptr_d     = ptr_q ^ 3'd1;
                            shift_d   = rd_byte;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RD;
                        end else begin
                            oe_n_d  = 1'b1;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    oe_n_d = 1'b1;
                end
                ST_IDLE: begin
                    oe_n_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_n_d  = 1'b1;
                end
            endcase
        end
    end

    // Loading a port's input register for a read re-arms that port's change detector.
    always_comb begin
        snap_d = snap_q;
        if (load_en) begin
            if (load_ptr == CMD_IN0) begin
                snap_d[7:0] = io_s3_q[7:0];
            end else if (load_ptr == CMD_IN1) begin
                snap_d[15:8] = io_s3_q[15:8];
            end
        end
        int_n_d = ~|((io_s3_q ^ snap_q) & cfg_q);
    end

    // Free-running pin synchronizer; it keeps tracking io_in during reset so
    // the snapshots can be initialized from it.
    always_ff @(posedge clk) begin
        io_s1_q <= io_in;
        io_s2_q <= io_s1_q;
        io_s3_q <= io_s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            ptr_q     <= 3'd0;
            rw_q      <= 1'b0;
            oe_n_q    <= 1'b1;
            out_q     <= OUT_RESET;
            pol_q     <= 16'd0;
            cfg_q     <= CFG_RESET;
            snap_q    <= io_s3_q;
            int_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            oe_n_q    <= oe_n_d;
            out_q     <= out_d;
            pol_q     <= pol_d;
            cfg_q     <= cfg_d;
            snap_q    <= snap_d;
            int_n_q   <= int_n_d;
        end
    end

    assign sdata_oe_n = oe_n_q;
    assign io_out     = out_q;
    assign io_dir     = cfg_q;
    assign int_n      = int_n_q;

endmodule

// File: tb/tb_i2c_ioexp_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_ioexp_target
// Bench for i2c_ioexp_target: an open-drain I2C master model drives byte
// transactions; expected ACKs, read data and register values go into a
// queue as stimulus is issued and are popped when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_i2c_ioexp_target;

    localparam int Q = 50;   // quarter of an SCL period in ns (200 ns SCL, 10 ns clk)

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        sda_m;
    logic        sdata_in;
    logic        sdata_oe_n;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [15:0] io_dir;
    logic        int_n;

    int          assert_count = 0;
    int          fail_count   = 0;
    int          low_cycles   = 0;
    int          low_mark;
    string       tag_q[$];
    logic [15:0] val_q[$];
    logic        dummy;

    // Wired-AND open-drain bus: either side can pull SDA low.
    assign sdata_in = sda_m & sdata_oe_n;

    always #5 clk = ~clk;

    // Counts every cycle the target pulls SDA low.
    always @(posedge clk) begin
        if (sdata_oe_n === 1'b0) low_cycles <= low_cycles + 1;
    end

    i2c_ioexp_target #(
        .ADDR      (7'h20),
        .OUT_RESET (16'hFFFF),
        .CFG_RESET (16'hFFFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .sdata_in   (sdata_in),
        .sdata_oe_n (sdata_oe_n),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_dir     (io_dir),
        .int_n      (int_n)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectValue(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic checkNext(input logic [15:0] observed);
        string       t;
        logic [15:0] v;
        if (val_q.size() == 0) begin
            checkOutput("scoreboard_empty", 16'(val_q.size()), 16'd1);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            checkOutput(t, observed, v);
        end
    endtask

    task automatic i2cBit(input logic b, output logic r);
        sda_m = b;
        #Q sclk = 1'b1;
        #Q r = sdata_in;
        #Q sclk = 1'b0;
        #Q;
    endtask

    task automatic i2cStart();
        sda_m = 1'b1;
        #Q sclk = 1'b1;
        #Q sda_m = 1'b0;
        #Q sclk = 1'b0;
        #Q;
    endtask

    task automatic i2cStop();
        sda_m = 1'b0;
        #Q sclk = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic exp_ack, input string tag);
        logic r;
        expectValue(tag, {15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) i2cBit(d[i], r);
        i2cBit(1'b1, r);
        checkNext({15'd0, r});
    endtask

    task automatic readByte(input logic [7:0] exp_data, input logic master_ack, input string tag);
        logic       r;
        logic [7:0] d;
        d = 8'd0;
        expectValue(tag, {8'd0, exp_data});
        for (int i = 0; i < 8; i++) begin
            i2cBit(1'b1, r);
            d = {d[6:0], r};
        end
        i2cBit(master_ack, r);
        checkNext({8'd0, d});
    endtask

    task automatic toggleIo(input logic [15:0] mask);
        @(negedge clk);
        io_in = io_in ^ mask;
    endtask

    initial begin
        reset = 1'b1;
        sclk  = 1'b1;
        sda_m = 1'b1;
        io_in = 16'h0000;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        expectValue("rst_oe_n", 16'h0001);   checkNext({15'd0, sdata_oe_n});
        expectValue("rst_int_n", 16'h0001);  checkNext({15'd0, int_n});
        expectValue("rst_io_out", 16'hFFFF); checkNext(io_out);
        expectValue("rst_io_dir", 16'hFFFF); checkNext(io_dir);

        // Output register write, auto-toggle to port 1
        i2cStart();
        applyStimulus(8'h40, 1'b0, "w1_addr_ack");
        applyStimulus(8'h02, 1'b0, "w1_cmd_ack");
        applyStimulus(8'hA5, 1'b0, "w1_d0_ack");
        applyStimulus(8'h3C, 1'b0, "w1_d1_ack");
        i2cStop();
        expectValue("w1_io_out", 16'h3CA5);  checkNext(io_out);

        // Polarity on port 0, then input read with repeated START
        toggleIo(16'hAA55);
        i2cStart();
        applyStimulus(8'h40, 1'b0, "pol_addr_ack");
        applyStimulus(8'h04, 1'b0, "pol_cmd_ack");
        applyStimulus(8'hFF, 1'b0, "pol_d_ack");
        i2cStop();
        i2cStart();
        applyStimulus(8'h40, 1'b0, "rd_addr_ack");
        applyStimulus(8'h00, 1'b0, "rd_cmd_ack");
        i2cStart();
        applyStimulus(8'h41, 1'b0, "rd_addr_r_ack");
        readByte(8'hAA, 1'b0, "rd_in0");
        readByte(8'hAA, 1'b1, "rd_in1");
        i2cStop();
        repeat (6) @(negedge clk);
        expectValue("rd_int_cleared", 16'h0001); checkNext({15'd0, int_n});

        // Wrong address: never driven, then a normal transaction still works
        low_mark = low_cycles;
        i2cStart();
        applyStimulus(8'h42, 1'b1, "bad_addr_nack");
        applyStimulus(8'h00, 1'b1, "bad_data_nack");
        i2cStop();
        expectValue("bad_sda_low_cycles", 16'h0000); checkNext(16'(low_cycles - low_mark));
        i2cStart();
        applyStimulus(8'h40, 1'b0, "after_bad_addr_ack");
        applyStimulus(8'h02, 1'b0, "after_bad_cmd_ack");
        i2cStop();

        // Configuration: port 0 low nibble inputs
        i2cStart();
        applyStimulus(8'h40, 1'b0, "cfg_addr_ack");
        applyStimulus(8'h06, 1'b0, "cfg_cmd_ack");
        applyStimulus(8'h0F, 1'b0, "cfg_d_ack");
        i2cStop();
        expectValue("cfg_io_dir", 16'hFF0F);   checkNext(io_dir);
        expectValue("cfg_int_idle", 16'h0001); checkNext({15'd0, int_n});

        i2cStart();
        applyStimulus(8'h40, 1'b0, "cfgrd_addr_ack");
        applyStimulus(8'h06, 1'b0, "cfgrd_cmd_ack");
        i2cStart();
        applyStimulus(8'h41, 1'b0, "cfgrd_addr_r_ack");
        readByte(8'h0F, 1'b0, "cfgrd_cfg0");
        readByte(8'hFF, 1'b1, "cfgrd_cfg1");
        i2cStop();

        // Interrupt latency on an input pin
        toggleIo(16'h0001);
        repeat (3) @(posedge clk);
        #1;
        expectValue("int_not_yet", 16'h0001); checkNext({15'd0, int_n});
        @(posedge clk);
        #1;
        expectValue("int_at_4", 16'h0000);    checkNext({15'd0, int_n});
        toggleIo(16'h0001);
        repeat (6) @(negedge clk);
        expectValue("int_revert", 16'h0001);  checkNext({15'd0, int_n});
        toggleIo(16'h0010);
        repeat (8) @(negedge clk);
        expectValue("int_output_pin", 16'h0001); checkNext({15'd0, int_n});
        toggleIo(16'h0001);
        repeat (6) @(negedge clk);
        expectValue("int_again", 16'h0000);   checkNext({15'd0, int_n});

        // io_in = AA44: port 0 reads 0x44 ^ 0xFF
        i2cStart();
        applyStimulus(8'h40, 1'b0, "intrd_addr_ack");
        applyStimulus(8'h00, 1'b0, "intrd_cmd_ack");
        i2cStart();
        applyStimulus(8'h41, 1'b0, "intrd_addr_r_ack");
        readByte(8'hBB, 1'b1, "intrd_in0");
        i2cStop();
        repeat (4) @(negedge clk);
        expectValue("int_cleared_by_read", 16'h0001); checkNext({15'd0, int_n});

        // Write to the read-only input register
        i2cStart();
        applyStimulus(8'h40, 1'b0, "ro_addr_ack");
        applyStimulus(8'h00, 1'b0, "ro_cmd_ack");
        applyStimulus(8'h12, 1'b0, "ro_d_ack");
        i2cStop();
        expectValue("ro_io_out", 16'h3CA5); checkNext(io_out);
        expectValue("ro_io_dir", 16'hFF0F); checkNext(io_dir);

        // STOP in the middle of a command byte
        i2cStart();
        applyStimulus(8'h40, 1'b0, "mid_addr_ack");
        for (int i = 0; i < 3; i++) i2cBit(1'b1, dummy);
        i2cStop();
        expectValue("mid_stop_oe_n", 16'h0001); checkNext({15'd0, sdata_oe_n});
        i2cStart();
        applyStimulus(8'h40, 1'b0, "post_mid_addr_ack");
        applyStimulus(8'h02, 1'b0, "post_mid_cmd_ack");
        applyStimulus(8'h5A, 1'b0, "post_mid_d_ack");
        i2cStop();
        expectValue("post_mid_io_out", 16'h3C5A); checkNext(io_out);

        // Reset while the target drives the address ACK
        i2cStart();
        for (int i = 7; i >= 0; i--) i2cBit(((8'h40 >> i) & 8'h01) != 8'h00, dummy);
        expectValue("ack_driving", 16'h0000); checkNext({15'd0, sdata_oe_n});
        reset = 1'b1;
        @(posedge clk);
        #1;
        expectValue("rst_mid_oe_n", 16'h0001);   checkNext({15'd0, sdata_oe_n});
        expectValue("rst_mid_io_out", 16'hFFFF); checkNext(io_out);
        expectValue("rst_mid_io_dir", 16'hFFFF); checkNext(io_dir);
        sclk  = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        expectValue("rst_mid_int_n", 16'h0001); checkNext({15'd0, int_n});
        i2cStart();
        applyStimulus(8'h40, 1'b0, "post_rst_addr_ack");
        i2cStop();

        checkOutput("scoreboard_leftover", 16'(val_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
